// File: rtl/rom_read_arbiter.sv
// ----------------------------------------------------------------------------
// rom_read_arbiter
// Shares one registered-read, single-port ROM (active-low chip select, one
// cycle read latency) between two read requesters.
//
// Arbitration and handshake:
// - Arbitration is round-robin on a req/ack handshake.
// - A requester holds req with a stable address until its one-cycle ack.
// - Read data and the out-of-range flag are registered per port.
// - Each port's data and flag hold until that port's next ack.
//
// Out-of-range and ack-cycle behaviour:
// - Out-of-range addresses are answered with err=1 and zero data.
// - Such requests never assert the ROM chip select.
// - The IDLE state overlaps the ack cycle.
// - The port being acknowledged is masked from arbitration for that cycle.
// - A waiting request from the other port therefore wins immediately.
// ----------------------------------------------------------------------------
module rom_read_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  err0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  err1,
    output logic                  rom_cs_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // One extra bit so that DEPTH == 2**ADDR_WIDTH is representable and the
    // range test becomes "never out of range".
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_gnt;        // port owning the current access
    logic                    r_last;       // port granted most recently
    logic                    r_bad;        // current access is out of range
    logic [ADDR_WIDTH-1:0]   r_rom_addr;
    logic                    r_ack0;
    logic                    r_ack1;
    logic [DATA_WIDTH-1:0]   r_rdata0;
    logic [DATA_WIDTH-1:0]   r_rdata1;
    logic                    r_err0;
    logic                    r_err1;

    logic                    w_elig0;
    logic                    w_elig1;
    logic                    w_grant;
    logic                    w_gnt_id;
    logic [ADDR_WIDTH-1:0]   w_gnt_addr;
    logic                    w_gnt_bad;
    logic                    w_rom_cs_n;

    // Round-robin grant decision, only meaningful while IDLE.
    always_comb begin
        w_elig0  = req0 & ~r_ack0;
        w_elig1  = req1 & ~r_ack1;
        w_grant  = 1'b0;
        w_gnt_id = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_elig0 && w_elig1) begin
                w_grant  = 1'b1;
                w_gnt_id = ~r_last;
            end else if (w_elig0) begin
                w_grant  = 1'b1;
                w_gnt_id = 1'b0;
            end else if (w_elig1) begin
                w_grant  = 1'b1;
                w_gnt_id = 1'b1;
            end else begin
                w_grant  = 1'b0;
                w_gnt_id = 1'b0;
            end
        end else begin
            w_grant  = 1'b0;
            w_gnt_id = 1'b0;
        end
        w_gnt_addr = w_gnt_id ? addr1 : addr0;
        w_gnt_bad  = ({1'b0, w_gnt_addr} >= DEPTH_W);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: out-of-range grants skip the ROM access entirely.
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_next_state = w_gnt_bad ? S_WAIT : S_READ;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_READ:  w_next_state = S_WAIT;
            S_WAIT:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: the ROM is selected only during READ.
    always_comb begin
        w_rom_cs_n = 1'b1;
        case (r_state)
            S_READ:  w_rom_cs_n = 1'b0;
            S_IDLE:  w_rom_cs_n = 1'b1;
            S_WAIT:  w_rom_cs_n = 1'b1;
            default: w_rom_cs_n = 1'b1;
        endcase
    end

    // Grant bookkeeping, ROM address, and per-port completion registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt      <= 1'b0;
            r_last     <= 1'b1;
            r_bad      <= 1'b0;
            r_rom_addr <= {ADDR_WIDTH{1'b0}};
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= {DATA_WIDTH{1'b0}};
            r_rdata1   <= {DATA_WIDTH{1'b0}};
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            if (w_grant) begin
                r_gnt      <= w_gnt_id;
                r_last     <= w_gnt_id;
                r_rom_addr <= w_gnt_addr;
                r_bad      <= w_gnt_bad;
            end
            if (r_state == S_WAIT) begin
                if (r_gnt == 1'b0) begin
                    r_ack0   <= 1'b1;
                    r_rdata0 <= r_bad ? {DATA_WIDTH{1'b0}} : rom_data;
                    r_err0   <= r_bad;
                end else begin
                    r_ack1   <= 1'b1;
                    r_rdata1 <= r_bad ? {DATA_WIDTH{1'b0}} : rom_data;
                    r_err1   <= r_bad;
                end
            end
        end
    end

    assign ack0     = r_ack0;
    assign rdata0   = r_rdata0;
    assign err0     = r_err0;
    assign ack1     = r_ack1;
    assign rdata1   = r_rdata1;
    assign err1     = r_err1;
    assign rom_cs_n = w_rom_cs_n;
    assign rom_addr = r_rom_addr;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for rom_read_arbiter.
//
// Stimulus structure:
// - A ROM model holds mem[i] = 32'hA5A5_0000 + i.
// - Single-port requests come from a table.
// - Hand-written sequences cover the arbitration and reset corner cases.
// - A randomized two-requester run follows.
//
// Checks in the randomized run:
// - It is compared against transaction-level rules: data per address, one ack
//   at a time, and bounded latency.
// - No port is passed over twice while waiting.
// - Exactly one ROM read occurs per legal request.
// ----------------------------------------------------------------------------
module tb_rom_read_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    typedef struct {
        logic          port;
        logic [AW-1:0] addr;
        logic [DW-1:0] exp_data;
        logic          exp_err;
        int            exp_lat;
        int            exp_cs;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rq [2];
    logic [AW-1:0] ad [2];
    logic          ack0, ack1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          rom_cs_n;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = 32'h0000_0000;

    int            total = 0;
    int            bad = 0;
    int            cs_count = 0;
    logic [AW-1:0] cs_last_addr = 16'h0000;

    always #5 clk = ~clk;

    rom_read_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (rq[0]),
        .addr0    (ad[0]),
        .ack0     (ack0),
        .rdata0   (rdata0),
        .err0     (err0),
        .req1     (rq[1]),
        .addr1    (ad[1]),
        .ack1     (ack1),
        .rdata1   (rdata1),
        .err1     (err1),
        .rom_cs_n (rom_cs_n),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return 32'hA5A5_0000 + DW'(a);
    endfunction

    function automatic logic legal(input logic [AW-1:0] a);
        return (int'(a) < DEPTH);
    endfunction

    // Registered-read ROM with active-low select.
    always @(posedge clk) begin
        if (!rom_cs_n) rom_data <= rom_word(rom_addr);
    end

    function automatic logic ack_of(input int p);
        return (p == 0) ? ack0 : ack1;
    endfunction

    function automatic logic [DW:0] out_of(input int p);
        return (p == 0) ? {err0, rdata0} : {err1, rdata1};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample on the falling edge.
    task automatic tick();
        @(negedge clk);
        if (rom_cs_n == 1'b0) begin
            cs_count++;
            cs_last_addr = rom_addr;
        end
    endtask

    task automatic wait_ack(input int p, input int limit, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (ack_of(p) != 1'b1 && lat < limit);
        if (ack_of(p) != 1'b1) lat = limit + 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs [6];
        int            p, lat, cs0, acks, n, t0, t1, legal_acks;
        int            order [6];
        int            nxt [2];
        int            wt [2];
        int            starve [2];
        logic [DW:0]   other;
        logic [DW:0]   exp_v [2];
        logic [DW-1:0] d0, d1;
        logic          prev, prev_cs, allow;

        rq[0] = 1'b0; rq[1] = 1'b0;
        ad[0] = 16'h0000; ad[1] = 16'h0000;

        vecs[0] = '{port:1'b0, addr:16'd2,      exp_data:32'hA5A5_0002, exp_err:1'b0, exp_lat:3, exp_cs:1};
        vecs[1] = '{port:1'b1, addr:16'd5,      exp_data:32'hA5A5_0005, exp_err:1'b0, exp_lat:3, exp_cs:1};
        vecs[2] = '{port:1'b0, addr:16'd15,     exp_data:32'hA5A5_000F, exp_err:1'b0, exp_lat:3, exp_cs:1};
        vecs[3] = '{port:1'b1, addr:16'd16,     exp_data:32'h0000_0000, exp_err:1'b1, exp_lat:2, exp_cs:0};
        vecs[4] = '{port:1'b0, addr:16'hFFFF,   exp_data:32'h0000_0000, exp_err:1'b1, exp_lat:2, exp_cs:0};
        vecs[5] = '{port:1'b1, addr:16'd0,      exp_data:32'hA5A5_0000, exp_err:1'b0, exp_lat:3, exp_cs:1};

        // Reset state while reset is held.
        tick();
        tick();
        check("reset rom_cs_n", rom_cs_n, 1'b1);
        check("reset rom_addr", rom_addr, 16'h0000);
        check("reset ack0", ack0, 1'b0);
        check("reset ack1", ack1, 1'b0);
        check("reset err0", err0, 1'b0);
        check("reset err1", err1, 1'b0);
        check("reset rdata0", rdata0, 32'h0000_0000);
        check("reset rdata1", rdata1, 32'h0000_0000);
        reset = 1'b0;

        // Single-port transactions from the table.
        for (int i = 0; i < 6; i++) begin
            p = int'(vecs[i].port);
            other = out_of(1 - p);
            cs0 = cs_count;
            ad[p] = vecs[i].addr;
            rq[p] = 1'b1;
            wait_ack(p, 8, lat);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d rdata/err", i), out_of(p), {vecs[i].exp_err, vecs[i].exp_data});
            rq[p] = 1'b0;
            tick();
            check($sformatf("vec%0d ack pulse width", i), ack_of(p), 1'b0);
            check($sformatf("vec%0d rom reads", i), cs_count - cs0, vecs[i].exp_cs);
            if (vecs[i].exp_cs == 1) check($sformatf("vec%0d rom addr", i), cs_last_addr, vecs[i].addr);
            check($sformatf("vec%0d other port held", i), out_of(1 - p), other);
        end

        // Simultaneous requests right after reset: port 0 first, port 1 granted in ack0 cycle.
        do_reset();
        ad[0] = 16'd3; ad[1] = 16'd5;
        rq[0] = 1'b1; rq[1] = 1'b1;
        t0 = -1; t1 = -1; d0 = 32'h0; d1 = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (ack0) begin t0 = c; d0 = rdata0; rq[0] = 1'b0; end
            if (ack1) begin t1 = c; d1 = rdata1; rq[1] = 1'b0; end
        end
        check("both-req ack0 cycle", t0, 3);
        check("both-req ack1 cycle", t1, 6);
        check("both-req rdata0", d0, 32'hA5A5_0003);
        check("both-req rdata1", d1, 32'hA5A5_0005);

        // Continuous requests on both ports: strict alternation.
        do_reset();
        nxt[0] = 0; nxt[1] = 0;
        ad[0] = 16'd4; ad[1] = 16'd7;
        rq[0] = 1'b1; rq[1] = 1'b1;
        n = 0; prev = 1'b0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            tick();
            if (ack0 || ack1) begin
                check("alternate no back-to-back ack", prev, 1'b0);
                check("alternate single ack", ack0 & ack1, 1'b0);
                p = ack1 ? 1 : 0;
                order[n] = p;
                check("alternate rdata", out_of(p), {1'b0, rom_word(ad[p])});
                n++;
                nxt[p]++;
                if (nxt[p] == 3) rq[p] = 1'b0;
                else ad[p] = ad[p] + 16'd2;
            end
            prev = ack0 | ack1;
        end
        rq[0] = 1'b0; rq[1] = 1'b0;
        check("alternate transaction count", n, 6);
        for (int k = 0; k < n; k++) check($sformatf("alternate order[%0d]", k), order[k], k % 2);
        tick();
        tick();

        // req0 held through its ack cycle: still exactly one ack and one ROM read.
        cs0 = cs_count;
        acks = 0;
        ad[0] = 16'd9; rq[0] = 1'b1;
        wait_ack(0, 8, lat);
        if (ack0) acks++;
        check("held-req latency", lat, 3);
        tick();
        if (ack0) acks++;
        rq[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ack0) acks++;
        end
        check("held-req ack count", acks, 1);
        check("held-req rom reads", cs_count - cs0, 1);

        // Reset during READ drops the access; a re-issued request completes.
        ad[0] = 16'd7; rq[0] = 1'b1;
        tick();
        check("reset-in-read reached READ", rom_cs_n, 1'b0);
        reset = 1'b1; rq[0] = 1'b0;
        tick();
        reset = 1'b0;
        check("reset-in-read rom_cs_n", rom_cs_n, 1'b1);
        check("reset-in-read ack0", ack0, 1'b0);
        check("reset-in-read rom_addr", rom_addr, 16'h0000);
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (ack0 || ack1) acks++;
        end
        check("reset-in-read no ack for dropped read", acks, 0);
        ad[0] = 16'd1; rq[0] = 1'b1;
        wait_ack(0, 8, lat);
        check("reset-in-read reissue latency", lat, 3);
        check("reset-in-read reissue rdata/err", {err0, rdata0}, {1'b0, 32'hA5A5_0001});
        rq[0] = 1'b0;
        tick();

        // Randomized two-requester traffic against the transaction-level model.
        do_reset();
        exp_v[0] = '0; exp_v[1] = '0;
        wt[0] = 0; wt[1] = 0;
        starve[0] = 0; starve[1] = 0;
        legal_acks = 0;
        cs0 = cs_count;
        prev_cs = 1'b0;
        for (int c = 0; c < 2400; c++) begin
            tick();
            allow = (c < 2000);
            if (!rom_cs_n) begin
                check("rnd rom addr legal", legal(rom_addr), 1'b1);
                check("rnd rom addr matches request",
                      (rq[0] && ad[0] == rom_addr) || (rq[1] && ad[1] == rom_addr), 1'b1);
                check("rnd rom cs single cycle", prev_cs, 1'b0);
            end
            prev_cs = ~rom_cs_n;
            if (ack0 || ack1) check("rnd ack exclusive", ack0 & ack1, 1'b0);
            for (int q = 0; q < 2; q++) begin
                if (rq[q]) wt[q]++;
                if (ack_of(q)) begin
                    check("rnd ack has request", rq[q], 1'b1);
                    check("rnd latency within 8", wt[q] <= 8, 1'b1);
                    exp_v[q] = legal(ad[q]) ? {1'b0, rom_word(ad[q])} : {1'b1, 32'h0000_0000};
                    if (legal(ad[q])) legal_acks++;
                    starve[q] = 0;
                    if (rq[1 - q] && !ack_of(1 - q)) begin
                        starve[1 - q]++;
                        check("rnd no starvation", starve[1 - q] <= 1, 1'b1);
                    end
                end
            end
            check("rnd port0 rdata/err", {err0, rdata0}, exp_v[0]);
            check("rnd port1 rdata/err", {err1, rdata1}, exp_v[1]);
            for (int q = 0; q < 2; q++) begin
                if (ack_of(q)) begin
                    rq[q] = 1'b0;
                end else if (rq[q] && wt[q] > 12) begin
                    total++;
                    bad++;
                    $display("FAIL rnd timeout port%0d: no ack after %0d cycles, required <= 8", q, wt[q]);
                    rq[q] = 1'b0;
                end else if (!rq[q] && allow && $urandom_range(0, 2) == 0) begin
                    ad[q] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16, 65535))
                                                        : 16'($urandom_range(0, 15));
                    rq[q] = 1'b1;
                    wt[q] = 0;
                end
            end
        end
        check("rnd rom reads equal legal acks", cs_count - cs0, legal_acks);
        check("rnd all requests drained", rq[0] | rq[1], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
